// File: rtl/reg_wb_unit_pkg.sv
// rtl/reg_wb_unit_pkg.sv - shared widths, writeback source codes and queue entry type
package reg_wb_unit_pkg;

   localparam int REG_ADDR_WIDTH = 5;
   localparam int REG_WIDTH      = 32;

   typedef enum logic [1:0] {
      WB_SRC_NONE = 2'd0,
      WB_SRC_ALU  = 2'd1,
      WB_SRC_LSU  = 2'd2
   } wb_src_e;

   typedef struct packed {
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic [REG_WIDTH-1:0]      data;
   } wb_entry_t;

   // x0 is hardwired, so it never matches anything in flight
   function automatic logic addr_hit(input logic [REG_ADDR_WIDTH-1:0] a,
                                     input logic [REG_ADDR_WIDTH-1:0] b);
      return (a != '0) && (a == b);
   endfunction

endpackage

// File: rtl/reg_wb_unit_wb_fifo.sv
// rtl/reg_wb_unit_wb_fifo.sv - synchronous LSU result queue exposing per-entry valid and rd
module wb_fifo
   import reg_wb_unit_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  push,
   input  wb_entry_t                             push_entry,
   input  logic                                  pop,
   output wb_entry_t                             head,
   output logic [CW-1:0]                         count,
   output logic [DEPTH-1:0]                      entry_valid,
   output logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0]  entry_rd
);

   wb_entry_t         mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_entry;
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         entry_valid <= '0;
      end else begin
         if (push) begin
            entry_valid[wr_ptr] <= 1'b1;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop) begin
            entry_valid[rd_ptr] <= 1'b0;
            rd_ptr              <= rd_ptr + 1'b1;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign head = mem[rd_ptr];

   always_comb begin
      entry_rd = '0;
      for (int i = 0; i < DEPTH; i++) entry_rd[i] = mem[i].rd;
   end

endmodule

// File: rtl/reg_wb_unit.sv
// rtl/reg_wb_unit.sv - register file writeback arbiter with operand bypass and LSU hazard detect
module reg_wb_unit
   import reg_wb_unit_pkg::*;
#(
   parameter int LSU_FIFO_DEPTH = 4,
   parameter int STARVE_LIMIT   = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      alu_valid,
   input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
   input  logic [REG_WIDTH-1:0]      alu_data,
   input  logic                      lsu_valid,
   output logic                      lsu_ready,
   input  logic [REG_ADDR_WIDTH-1:0] lsu_rd,
   input  logic [REG_WIDTH-1:0]      lsu_data,
   output logic                      alu_stall,
   output logic                      reg_wen,
   output logic [REG_ADDR_WIDTH-1:0] reg_w_addr,
   output logic [REG_WIDTH-1:0]      reg_w_data,
   input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
   input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
   input  logic [REG_ADDR_WIDTH-1:0] hz_rd,
   input  logic [REG_WIDTH-1:0]      rf_rdata1,
   input  logic [REG_WIDTH-1:0]      rf_rdata2,
   output logic [REG_WIDTH-1:0]      op_data1,
   output logic [REG_WIDTH-1:0]      op_data2,
   output logic                      lsu_hazard
);

   localparam int CW = $clog2(LSU_FIFO_DEPTH) + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0]                              count;
   logic                                       q_empty;
   logic                                       push;
   logic                                       pop;
   wb_entry_t                                  head;
   logic [LSU_FIFO_DEPTH-1:0]                  entry_valid;
   logic [LSU_FIFO_DEPTH-1:0][REG_ADDR_WIDTH-1:0] entry_rd;
   wb_src_e                                    sel;
   logic [SW-1:0]                              starve_cnt;
   logic [SW-1:0]                              starve_next;

   assign q_empty   = (count == '0);
   assign lsu_ready = (count != CW'(LSU_FIFO_DEPTH));
   // Writes to x0 are acknowledged but never occupy a queue slot
   assign push      = lsu_valid && lsu_ready && (lsu_rd != '0);
   assign pop       = (sel == WB_SRC_LSU);

   wb_fifo #(.DEPTH(LSU_FIFO_DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .push_entry  ('{rd: lsu_rd, data: lsu_data}),
      .pop         (pop),
      .head        (head),
      .count       (count),
      .entry_valid (entry_valid),
      .entry_rd    (entry_rd)
   );

   always_comb begin
      sel = WB_SRC_NONE;
      if (alu_valid && (alu_rd != '0)) sel = WB_SRC_ALU;
      else if (!q_empty)               sel = WB_SRC_LSU;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reg_wen    <= 1'b0;
         reg_w_addr <= '0;
         reg_w_data <= '0;
      end else begin
         case (sel)
            WB_SRC_ALU: begin
               reg_wen    <= 1'b1;
               reg_w_addr <= alu_rd;
               reg_w_data <= alu_data;
            end
            WB_SRC_LSU: begin
               reg_wen    <= 1'b1;
               reg_w_addr <= head.rd;
               reg_w_data <= head.data;
            end
            default: reg_wen <= 1'b0;
         endcase
      end
   end

   // Counts ALU wins over a waiting queue; saturates at the limit
   always_comb begin
      starve_next = starve_cnt;
      if (pop || q_empty)
         starve_next = '0;
      else if (sel == WB_SRC_ALU && starve_cnt < SW'(STARVE_LIMIT))
         starve_next = starve_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
         alu_stall  <= 1'b0;
      end else begin
         starve_cnt <= starve_next;
         alu_stall  <= (starve_next >= SW'(STARVE_LIMIT));
      end
   end

   always_comb begin
      lsu_hazard = 1'b0;
      for (int i = 0; i < LSU_FIFO_DEPTH; i++) begin
         if (entry_valid[i] && (addr_hit(rs1_addr, entry_rd[i]) ||
                                addr_hit(rs2_addr, entry_rd[i]) ||
                                addr_hit(hz_rd, entry_rd[i])))
            lsu_hazard = 1'b1;
      end
   end

   assign op_data1 = (rs1_addr == '0) ? '0 :
                     (reg_wen && reg_w_addr == rs1_addr) ? reg_w_data : rf_rdata1;
   assign op_data2 = (rs2_addr == '0) ? '0 :
                     (reg_wen && reg_w_addr == rs2_addr) ? reg_w_data : rf_rdata2;

endmodule

// File: tb/tb_reg_wb_unit.sv
// tb/tb_reg_wb_unit.sv - scoreboard bench for reg_wb_unit writeback ordering, queue, bypass and hazards
module tb_reg_wb_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        alu_stall;
   logic        reg_wen;
   logic [4:0]  reg_w_addr;
   logic [31:0] reg_w_data;
   logic [4:0]  rs1_addr, rs2_addr, hz_rd;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic [31:0] op_data1, op_data2;
   logic        lsu_hazard;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   reg_wb_unit #(.LSU_FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .alu_stall(alu_stall),
      .reg_wen(reg_wen), .reg_w_addr(reg_w_addr), .reg_w_data(reg_w_data),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .hz_rd(hz_rd),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .op_data1(op_data1), .op_data2(op_data2), .lsu_hazard(lsu_hazard)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
      exp_t e;
      e.rd   = rd;
      e.data = data;
      sb.push_back(e);
   endtask

   // Monitor: every register write must match the head of the scoreboard
   always @(negedge clk) begin
      if (reg_wen === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_write_addr", {27'd0, reg_w_addr}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("wr_addr", {27'd0, reg_w_addr}, {27'd0, e.rd});
            check("wr_data", reg_w_data, e.data);
         end
      end
   end

   initial begin
      rst = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
      rs1_addr = 0; rs2_addr = 0; hz_rd = 0; rf_rdata1 = 0; rf_rdata2 = 0;
      step(); step();
      check("rst_wen", {31'd0, reg_wen}, 0);
      check("rst_addr", {27'd0, reg_w_addr}, 0);
      check("rst_data", reg_w_data, 0);
      check("rst_ready", {31'd0, lsu_ready}, 1);
      check("rst_stall", {31'd0, alu_stall}, 0);
      check("rst_hazard", {31'd0, lsu_hazard}, 0);
      rst = 1'b0;
      rs1_addr = 3; rf_rdata1 = 32'h55;
      #1 check("rf_passthru", op_data1, 32'h55);

      // ALU single write, then rd=0 drop with hold of last address/data
      alu_valid = 1; alu_rd = 5; alu_data = 32'hA5; expect_wr(5, 32'hA5);
      step();
      check("alu_wen", {31'd0, reg_wen}, 1);
      alu_rd = 0; alu_data = 32'h1;
      step();
      check("alu_rd0_wen", {31'd0, reg_wen}, 0);
      check("hold_addr", {27'd0, reg_w_addr}, 5);
      check("hold_data", reg_w_data, 32'hA5);

      // Bypass of in-flight write
      alu_rd = 9; alu_data = 32'hDEAD; expect_wr(9, 32'hDEAD);
      rs1_addr = 9; rf_rdata1 = 0; rs2_addr = 0; rf_rdata2 = 32'h77;
      step();
      alu_valid = 0;
      #1;
      check("byp_op1", op_data1, 32'hDEAD);
      check("byp_op2_x0", op_data2, 0);
      rs2_addr = 9; rs1_addr = 4; rf_rdata1 = 32'h44;
      #1;
      check("byp_op2", op_data2, 32'hDEAD);
      check("byp_nomatch", op_data1, 32'h44);
      step();
      rs1_addr = 9; rf_rdata1 = 32'h99;
      #1 check("byp_idle", op_data1, 32'h99);
      rs1_addr = 0; rs2_addr = 0;

      // LSU with idle ALU: queued one cycle, hazard visible meanwhile
      lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h1234; expect_wr(7, 32'h1234);
      step();
      lsu_valid = 0; rs1_addr = 7;
      #1 check("lsu_hazard_set", {31'd0, lsu_hazard}, 1);
      check("lsu_not_yet", {31'd0, reg_wen}, 0);
      step();
      check("lsu_hazard_clr", {31'd0, lsu_hazard}, 0);
      rs1_addr = 0;

      // Fill queue under continuous ALU traffic; starvation then drain
      hz_rd = 3;
      for (int c = 0; c < 10; c++) begin
         alu_valid = 1; alu_rd = 5'(10 + c); alu_data = 32'hA000 + c;
         expect_wr(5'(10 + c), 32'hA000 + c);
         if (c < 4) begin
            lsu_valid = 1; lsu_rd = 5'(1 + c); lsu_data = 32'h100 + c;
         end else if (c == 4) begin
            check("full_ready", {31'd0, lsu_ready}, 0);
            lsu_valid = 1; lsu_rd = 20; lsu_data = 32'hBAD;
         end else begin
            lsu_valid = 0;
         end
         step();
         if (c == 2) check("ready_before_4th", {31'd0, lsu_ready}, 1);
         if (c == 3) check("ready_after_4th", {31'd0, lsu_ready}, 0);
         if (c == 3) check("hz_rd_hazard", {31'd0, lsu_hazard}, 1);
         if (c == 7) check("stall_7", {31'd0, alu_stall}, 0);
         if (c == 8) check("stall_8", {31'd0, alu_stall}, 1);
      end
      alu_valid = 0; lsu_valid = 0; hz_rd = 0;
      for (int i = 0; i < 4; i++) expect_wr(5'(1 + i), 32'h100 + i);
      step();
      check("stall_clr_on_pop", {31'd0, alu_stall}, 0);
      check("ready_after_pop", {31'd0, lsu_ready}, 1);
      lsu_valid = 1; lsu_rd = 6; lsu_data = 32'h600; expect_wr(6, 32'h600);
      step();
      lsu_valid = 0;
      check("ready_push_pop", {31'd0, lsu_ready}, 1);
      repeat (6) step();
      check("drain_idle", {31'd0, reg_wen}, 0);

      // Drain order with ALU x0 writes not blocking the queue
      alu_valid = 1; alu_rd = 0;
      for (int i = 0; i < 3; i++) begin
         lsu_valid = 1; lsu_rd = 5'(1 + i); lsu_data = 32'hC00 + i;
         expect_wr(5'(1 + i), 32'hC00 + i);
         step();
      end
      lsu_valid = 0; alu_valid = 0;
      lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hF00;
      step();
      lsu_valid = 0;
      repeat (4) step();

      // Reset with three results queued behind ALU traffic
      for (int c = 0; c < 3; c++) begin
         alu_valid = 1; alu_rd = 5'(11 + c); alu_data = 32'hE00 + c;
         expect_wr(5'(11 + c), 32'hE00 + c);
         lsu_valid = 1; lsu_rd = 5'(21 + c); lsu_data = 32'hD00 + c;
         step();
      end
      alu_valid = 0; lsu_valid = 0; rst = 1; rs1_addr = 21;
      step();
      check("rst_q_wen", {31'd0, reg_wen}, 0);
      check("rst_q_ready", {31'd0, lsu_ready}, 1);
      check("rst_q_hazard", {31'd0, lsu_hazard}, 0);
      rst = 0;
      repeat (6) step();
      check("sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
